// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and constants for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_sup_state_e;

  localparam int LOL_CNT_W   = 8;
  localparam int RETRY_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// rtl/pll_sup_sync.sv - multi-flop synchronizer for the asynchronous PLL lock indication
module pll_sup_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer with retry budget and sticky fault
// Optional loss-of-lock counter port o_lol_count is built when PLL_SUP_LOL_CNT_EN is defined.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                   i_refclk,
  input  logic                   i_rst,
  input  logic                   i_pll_locked,
  input  logic                   i_sw_relock,
  output logic                   o_pll_rst,
  output logic                   o_domain_rst_req,
  output logic                   o_ready,
  output logic                   o_fault,
`ifdef PLL_SUP_LOL_CNT_EN
  output logic [LOL_CNT_W-1:0]   o_lol_count,
`endif
  output logic [RETRY_CNT_W-1:0] o_retry_cnt
);

  localparam int MAX_CYC     = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W       = $clog2(MAX_CYC) + 1;
  localparam int RETRY_LIMIT = (MAX_RETRIES > 255) ? 255 : MAX_RETRIES;

  pll_sup_state_e         r_state;
  pll_sup_state_e         w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [RETRY_CNT_W-1:0] r_retry;
  logic [RETRY_CNT_W-1:0] w_retry_next;
  logic                   w_locked_s;
  logic                   w_lol_event;
  logic                   w_hold_done;
  logic                   w_lock_timeout;
  logic                   w_stable_done;
  logic                   w_retry_spent;
  logic                   w_pll_rst;
  logic                   w_drq;
  logic                   w_ready;
  logic                   w_fault;

  pll_sup_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .i_clk(i_refclk),
    .i_rst(i_rst),
    .i_d  (i_pll_locked),
    .o_q  (w_locked_s)
  );

  assign w_hold_done    = (r_cnt == CNT_W'(RST_HOLD_CYCLES - 1));
  assign w_lock_timeout = (r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));
  assign w_stable_done  = (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1));
  assign w_retry_spent  = (r_retry == RETRY_CNT_W'(RETRY_LIMIT));

  // The counter restarts whenever the state changes, so it measures time spent in the current state.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_retry <= w_retry_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_lol_event  = 1'b0;
    case (r_state)
      HOLD: begin
        if (w_hold_done) begin
          w_next = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (i_sw_relock) begin
          w_next       = HOLD;
          w_retry_next = '0;
        end else if (w_locked_s) begin
          w_next = STABLE;
        end else if (w_lock_timeout) begin
          if (w_retry_spent) begin
            w_next = FAULT;
          end else begin
            w_next       = HOLD;
            w_retry_next = r_retry + 1'b1;
          end
        end
      end
      STABLE: begin
        if (i_sw_relock) begin
          w_next       = HOLD;
          w_retry_next = '0;
        end else if (!w_locked_s) begin
          w_next = WAIT_LOCK;
        end else if (w_stable_done) begin
          w_next = RUN;
        end
      end
      RUN: begin
        // Lock loss together with a relock request is still one loss-of-lock event.
        if (!w_locked_s || i_sw_relock) begin
          w_next       = HOLD;
          w_retry_next = '0;
          w_lol_event  = !w_locked_s;
        end
      end
      FAULT: begin
        if (i_sw_relock) begin
          w_next       = HOLD;
          w_retry_next = '0;
        end
      end
      default: begin
        w_next = HOLD;
      end
    endcase
  end

  always_comb begin
    w_pll_rst = 1'b1;
    w_drq     = 1'b1;
    w_ready   = 1'b0;
    w_fault   = 1'b0;
    case (w_next)
      WAIT_LOCK, STABLE: begin
        w_pll_rst = 1'b0;
      end
      RUN: begin
        w_pll_rst = 1'b0;
        w_drq     = 1'b0;
        w_ready   = 1'b1;
      end
      FAULT: begin
        w_fault = 1'b1;
      end
      default: begin
        w_pll_rst = 1'b1;
      end
    endcase
  end

  // Registered from the next-state decode so outputs change in the state-entry cycle.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      o_pll_rst        <= 1'b1;
      o_domain_rst_req <= 1'b1;
      o_ready          <= 1'b0;
      o_fault          <= 1'b0;
    end else begin
      o_pll_rst        <= w_pll_rst;
      o_domain_rst_req <= w_drq;
      o_ready          <= w_ready;
      o_fault          <= w_fault;
    end
  end

  assign o_retry_cnt = r_retry;

`ifdef PLL_SUP_LOL_CNT_EN
  logic [LOL_CNT_W-1:0] r_lol;

  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_lol <= '0;
    end else if (w_lol_event && (r_lol != '1)) begin
      r_lol <= r_lol + 1'b1;
    end
  end

  assign o_lol_count = r_lol;
`else
  logic w_unused_lol_event;
  assign w_unused_lol_event = w_lol_event;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor (PLL_SUP_LOL_CNT_EN aware)
module tb_pll_lock_supervisor;

  localparam int HOLD_C = 4;
  localparam int ST_C   = 8;
  localparam int TO_C   = 32;
  localparam int MAXR   = 2;

  typedef struct {
    int cyc;
    bit prst;
    bit drq;
    bit rdy;
    bit flt;
    int retry;
    int lol;
  } obs_t;

  logic       clk;
  logic       i_rst;
  logic       i_pll_locked;
  logic       i_sw_relock;
  logic       o_pll_rst;
  logic       o_domain_rst_req;
  logic       o_ready;
  logic       o_fault;
  logic [7:0] o_retry_cnt;
  logic [7:0] lol_val;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t sb[$];

  // Reference model: phase name, entry edge, and input history indexed by edge number.
  string m_phase   = "hold";
  int    m_entered = 0;
  int    m_edge    = 0;
  int    m_retry   = 0;
  int    m_lol     = 0;
  obs_t  m_last    = '{cyc: 0, prst: 1'b1, drq: 1'b1, rdy: 1'b0, flt: 1'b0, retry: 0, lol: 0};
  bit    h_rst[$];
  bit    h_lk[$];

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES    (HOLD_C),
    .LOCK_STABLE_CYCLES (ST_C),
    .LOCK_TIMEOUT_CYCLES(TO_C),
    .MAX_RETRIES        (MAXR),
    .SYNC_STAGES        (2)
  ) dut (
    .i_refclk        (clk),
    .i_rst           (i_rst),
    .i_pll_locked    (i_pll_locked),
    .i_sw_relock     (i_sw_relock),
    .o_pll_rst       (o_pll_rst),
    .o_domain_rst_req(o_domain_rst_req),
    .o_ready         (o_ready),
    .o_fault         (o_fault),
`ifdef PLL_SUP_LOL_CNT_EN
    .o_lol_count     (lol_val),
`endif
    .o_retry_cnt     (o_retry_cnt)
  );

`ifndef PLL_SUP_LOL_CNT_EN
  assign lol_val = 8'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The FSM sees the lock value sampled two edges earlier, forced low if reset hit either sync edge.
  function automatic bit locked_seen(input int e);
    if (e < 2) return 1'b0;
    if (h_rst[e-1] || h_rst[e-2]) return 1'b0;
    return h_lk[e-2];
  endfunction

  function automatic bit same_vals(input obs_t a, input obs_t b);
    return (a.prst == b.prst) && (a.drq == b.drq) && (a.rdy == b.rdy) &&
           (a.flt == b.flt) && (a.retry == b.retry) && (a.lol == b.lol);
  endfunction

  task automatic model_edge(input bit rst, input bit lk, input bit rl);
    int    e;
    int    cnt;
    bit    ls;
    string nxt;
    obs_t  o;
    e = m_edge;
    h_rst.push_back(rst);
    h_lk.push_back(lk);
    ls  = locked_seen(e);
    cnt = e - m_entered - 1;
    nxt = m_phase;
    if (rst) begin
      m_phase   = "hold";
      m_entered = e;
      m_retry   = 0;
      m_lol     = 0;
    end else begin
      if (m_phase == "hold") begin
        if (cnt == HOLD_C - 1) nxt = "wait";
      end else if (m_phase == "wait") begin
        if (rl) begin
          nxt = "hold"; m_retry = 0;
        end else if (ls) begin
          nxt = "stable";
        end else if (cnt == TO_C - 1) begin
          if (m_retry == MAXR) nxt = "fault";
          else begin nxt = "hold"; m_retry = m_retry + 1; end
        end
      end else if (m_phase == "stable") begin
        if (rl) begin
          nxt = "hold"; m_retry = 0;
        end else if (!ls) begin
          nxt = "wait";
        end else if (cnt == ST_C - 1) begin
          nxt = "run";
        end
      end else if (m_phase == "run") begin
        if (!ls || rl) begin
          if (!ls && m_lol < 255) m_lol = m_lol + 1;
          m_retry = 0;
          nxt = "hold";
        end
      end else if (m_phase == "fault") begin
        if (rl) begin nxt = "hold"; m_retry = 0; end
      end
      if (nxt != m_phase) begin
        m_phase   = nxt;
        m_entered = e;
      end
    end
    o.cyc   = e;
    o.prst  = (m_phase == "hold") || (m_phase == "fault");
    o.drq   = (m_phase != "run");
    o.rdy   = (m_phase == "run");
    o.flt   = (m_phase == "fault");
    o.retry = m_retry;
`ifdef PLL_SUP_LOL_CNT_EN
    o.lol   = m_lol;
`else
    o.lol   = 0;
`endif
    if (!same_vals(o, m_last)) sb.push_back(o);
    m_last = o;
    m_edge = m_edge + 1;
  endtask

  task automatic step(input bit rst, input bit lk, input bit rl);
    i_rst        = rst;
    i_pll_locked = lk;
    i_sw_relock  = rl;
    model_edge(rst, lk, rl);
    @(negedge clk);
  endtask

  task automatic wait_phase(input string tgt, input bit lk, input int budget);
    int n;
    n = 0;
    while (m_phase != tgt && n < budget) begin
      step(1'b0, lk, 1'b0);
      n++;
    end
    if (m_phase != tgt) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_%s got phase=%s after %0d cycles", tgt, m_phase, budget);
    end
  endtask

  // Monitor: every DUT output change must match the next expected change, at the same edge.
  initial begin
    int   k;
    obs_t cur;
    obs_t prev;
    obs_t ex;
    k    = 0;
    prev = '{cyc: 0, prst: 1'b1, drq: 1'b1, rdy: 1'b0, flt: 1'b0, retry: 0, lol: 0};
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc < k) begin
        ex = sb.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missed_change cyc=%0d required prst=%0b drq=%0b rdy=%0b flt=%0b retry=%0d lol=%0d",
                 ex.cyc, ex.prst, ex.drq, ex.rdy, ex.flt, ex.retry, ex.lol);
      end
      cur = '{cyc: k, prst: o_pll_rst, drq: o_domain_rst_req, rdy: o_ready, flt: o_fault,
              retry: int'(o_retry_cnt), lol: int'(lol_val)};
      if (k == 0) begin
        n_checks++;
        if (!same_vals(cur, prev)) begin
          n_errors++;
          $display("FAIL reset_state got prst=%0b drq=%0b rdy=%0b flt=%0b retry=%0d lol=%0d required 1 1 0 0 0 0",
                   cur.prst, cur.drq, cur.rdy, cur.flt, cur.retry, cur.lol);
        end
      end else if (!same_vals(cur, prev)) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_change cyc=%0d got prst=%0b drq=%0b rdy=%0b flt=%0b retry=%0d lol=%0d",
                   k, cur.prst, cur.drq, cur.rdy, cur.flt, cur.retry, cur.lol);
        end else begin
          ex = sb.pop_front();
          if (ex.cyc != k || !same_vals(cur, ex)) begin
            n_errors++;
            $display("FAIL out_change cyc=%0d got prst=%0b drq=%0b rdy=%0b flt=%0b retry=%0d lol=%0d required cyc=%0d prst=%0b drq=%0b rdy=%0b flt=%0b retry=%0d lol=%0d",
                     k, cur.prst, cur.drq, cur.rdy, cur.flt, cur.retry, cur.lol,
                     ex.cyc, ex.prst, ex.drq, ex.rdy, ex.flt, ex.retry, ex.lol);
          end
        end
      end
      prev = cur;
      k++;
    end
  end

  initial begin
    int len;
    bit lk;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    // Lock arrives 10 cycles after pll_rst falls.
    wait_phase("wait", 1'b0, 20);
    repeat (9) step(1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0);
    // Loss of lock in RUN, then recovery.
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (50) step(1'b0, 1'b1, 1'b0);
    // One-cycle glitch at stable cycle 5.
    step(1'b0, 1'b1, 1'b1);
    wait_phase("stable", 1'b1, 40);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0);
    // No lock: retries exhaust into FAULT, then relock recovers.
    repeat (140) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (60) step(1'b0, 1'b1, 1'b0);
    // Reset mid-STABLE and mid-RUN.
    step(1'b0, 1'b1, 1'b1);
    wait_phase("stable", 1'b1, 40);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    wait_phase("run", 1'b1, 60);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0);
    // Randomized lock waveform with sporadic relock and reset.
    for (int s = 0; s < 80; s++) begin
      lk  = 1'($urandom_range(1));
      len = $urandom_range(1, lk ? 40 : 45);
      for (int c = 0; c < len; c++) begin
        step(($urandom_range(999) < 8) ? 1'b1 : 1'b0, lk,
             ($urandom_range(99) < 3) ? 1'b1 : 1'b0);
      end
    end
    repeat (5) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_expected got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
